alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage of the CPU: consumes the 4-bit ALU control code produced by ALU control plus operands and
//  produces the 32-bit result and branch flag. Single-cycle ops take 1 cycle; signed multiply (SMUL) runs
//  on an iterative shift-add engine. Valid/ready on both sides lets the pipeline stall during SMUL.
// PARAMETERS
//  DATA_W    32  operand/result width (only 32 is supported; shift amounts use 5 bits)
//  MUL_STEPS 32  maximum multiply iterations, equal to DATA_W
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   asynchronous active-low reset
//  flush_i      in   1   synchronous abort of the in-flight op and any held result
//  in_valid_i   in   1   operands and op are valid
//  in_ready_o   out  1   unit accepts this cycle; transfer occurs on in_valid_i & in_ready_o
//  alu_ctrl_i   in   4   op code: AND=0 OR=1 LW=2 SW=3 ADDU=4 SUBU=5 SLT=6 BLEZ=7 SRA=8 SRAV=9 LUI=10
//                        SLTU=11 SLL=12 SMUL=13 BGTZ=14; 15 is reserved
//  src1_i       in   32  operand A (rs)
//  src2_i       in   32  operand B (rt or extended immediate)
//  shamt_i      in   5   constant shift amount
//  out_valid_o  out  1   result_o/zero_o are valid
//  out_ready_i  in   1   consumer takes the result; transfer on out_valid_o & out_ready_i
//  result_o     out  32  registered result
//  zero_o       out  1   registered, equals (result_o == 0)
//  busy_o       out  1   high while in S_MUL
// BEHAVIOUR
//  Reset values: state S_IDLE, result_o 0, zero_o 0, out_valid_o 0, busy_o 0, in_ready_o 1.
//  Ops (32-bit, wrap-around, no overflow trap):
//   AND a&b; OR a|b; LW/SW/ADDU a+b; SUBU a-b; SLT signed a<b ? 1 : 0; SLTU unsigned a<b ? 1 : 0
//   SRA b>>>shamt_i; SRAV b>>>a[4:0]; SLL b<<shamt_i; LUI {b[15:0],16'h0}
//   BLEZ: result = ($signed(a) <= 0) ? 0 : 1; BGTZ: result = ($signed(a) > 0) ? 0 : 1 (zero_o=1 means taken)
//   SMUL: low 32 bits of $signed(a) * $signed(b); code 15 gives result 0.
//  FSM:
//   S_IDLE: in_ready_o=1. On accept: non-SMUL op loads result and moves to S_OUT (latency 1).
//           SMUL loads mcand=|a|, mplier=|b|, neg=a[31]^b[31], acc=0, cnt=0 and moves to S_MUL.
//   S_MUL:  in_ready_o=0. Each edge: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; cnt++.
//           Finish when cnt==31 on this step: result = neg ? -acc : acc, then move to S_OUT.
//           Full-length latency is 32 edges after the accept edge.
//   S_OUT:  out_valid_o=1; result held stable while out_ready_i=0. in_ready_o = out_ready_i.
//           On a transfer, a simultaneous accept is handled as from S_IDLE (back-to-back,
//           1 op/cycle for single-cycle ops); otherwise move to S_IDLE.
//  |0x80000000| is treated as unsigned 0x80000000, so INT_MIN operands are handled correctly.
//  flush_i has priority over every event: next state is S_IDLE, out_valid_o=0, and no accept occurs that cycle.
//  Asynchronous reset mid-multiply discards the operation. in_ready_o is combinational from state and out_ready_i.
// CONFIGURATION
//  ALU_MUL_EARLY_EXIT_EN defined: S_MUL also finishes when (mplier>>1)==0 after the current step.
//   Examples: b=0 or b=1 finishes 1 edge after accept; b=3 finishes after 2 edges.
//  ALU_MUL_EARLY_EXIT_EN not defined: SMUL always takes exactly 32 iteration edges.
//  The result value is identical in both builds.
// STRUCTURE
//  Shared package alu_ctrl_pkg holds the 4-bit op-code localparams (shared with ALU control) and the
//  state encoding S_IDLE/S_MUL/S_OUT.
//  Sub-module alu_seq_mult holds the mcand/mplier/acc/cnt datapath with start/done signals and sign fix.
//  The top level holds the FSM, the combinational single-cycle ALU and the output register.
// TESTING
//  1) ADDU 0x7FFFFFFF+1, out_ready_i=1 -> out_valid_o next cycle, result 0x80000000, zero_o 0
//  2) Back-to-back SUBU 5-5 then SLT -1<1 with out_ready_i held 1 -> results 0 (zero_o 1) then 1, one per cycle
//  3) SMUL -3*7 -> busy_o for 32 cycles, then result 0xFFFFFFEB; early-exit build: done after 3 iteration edges
//  4) SMUL 0x80000000*-1 -> 0x80000000; SMUL 0x10000*0x10000 -> 0
//  5) Result pending with out_ready_i=0 for 5 cycles -> result_o stable, in_ready_o 0; then a transfer
//  6) flush_i at SMUL iteration 10 -> S_IDLE next cycle, no out_valid_o; rst_i low mid-SMUL -> all outputs at reset values

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control op codes and execute-stage state encoding
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_ADDU = 4'd4;
    localparam logic [3:0] OP_SUBU = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_BLEZ = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SRAV = 4'd9;
    localparam logic [3:0] OP_LUI  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;
    localparam logic [3:0] OP_SLL  = 4'd12;
    localparam logic [3:0] OP_SMUL = 4'd13;
    localparam logic [3:0] OP_BGTZ = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mult.sv
// rtl/alu_seq_mult.sv - iterative shift-add signed multiplier, low-half product
// Optional ALU_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module alu_seq_mult #(
    parameter int DATA_W    = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [4:0]        cnt;
    logic              neg;
    logic              last_step;

    assign acc_next = mplier[0] ? acc + mcand : acc;

`ifdef ALU_MUL_EARLY_EXIT_EN
    assign last_step = (cnt == 5'(MUL_STEPS - 1)) || ((mplier >> 1) == '0);
`else
    assign last_step = (cnt == 5'(MUL_STEPS - 1));
`endif

    // done and product reflect the step taken on this edge, so the caller can register them directly
    assign done    = step && last_step;
    assign product = neg ? -acc_next : acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else if (start) begin
            // negating INT_MIN yields the same bit pattern, which is the correct unsigned magnitude
            mcand  <= a[DATA_W-1] ? -a : a;
            mplier <= b[DATA_W-1] ? -b : b;
            neg    <= a[DATA_W-1] ^ b[DATA_W-1];
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute stage: single-cycle ALU, iterative SMUL, valid/ready handshake
// Optional ALU_MUL_EARLY_EXIT_EN shortens SMUL latency inside alu_seq_mult.
module alu_exec_unit #(
    parameter int DATA_W    = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        alu_ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [4:0]        shamt_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              busy_o
);
    import alu_ctrl_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              load_en;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] alu_res;
    logic              mul_start;
    logic              mul_step;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign in_ready_o  = (state == S_IDLE) || ((state == S_OUT) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign out_valid_o = (state == S_OUT);
    assign busy_o      = (state == S_MUL);
    assign mul_step    = (state == S_MUL) && !flush_i;

    always_comb begin
        alu_res = '0;
        case (alu_ctrl_i)
            OP_AND:                 alu_res = src1_i & src2_i;
            OP_OR:                  alu_res = src1_i | src2_i;
            OP_LW, OP_SW, OP_ADDU:  alu_res = src1_i + src2_i;
            OP_SUBU:                alu_res = src1_i - src2_i;
            OP_SLT:                 alu_res = ($signed(src1_i) < $signed(src2_i)) ? 32'd1 : 32'd0;
            OP_SLTU:                alu_res = (src1_i < src2_i) ? 32'd1 : 32'd0;
            OP_SRA:                 alu_res = $unsigned($signed(src2_i) >>> shamt_i);
            OP_SRAV:                alu_res = $unsigned($signed(src2_i) >>> src1_i[4:0]);
            OP_SLL:                 alu_res = src2_i << shamt_i;
            OP_LUI:                 alu_res = {src2_i[15:0], 16'h0000};
            // branch ops report "taken" as a zero result so zero_o doubles as the branch flag
            OP_BLEZ:                alu_res = ($signed(src1_i) <= 32'sd0) ? 32'd0 : 32'd1;
            OP_BGTZ:                alu_res = ($signed(src1_i) > 32'sd0) ? 32'd0 : 32'd1;
            default:                alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        load_val  = alu_res;
        mul_start = 1'b0;
        if (flush_i) begin
            state_nxt = S_IDLE;
        end else if (accept) begin
            if (alu_ctrl_i == OP_SMUL) begin
                state_nxt = S_MUL;
                mul_start = 1'b1;
            end else begin
                state_nxt = S_OUT;
                load_en   = 1'b1;
            end
        end else begin
            case (state)
                S_MUL: begin
                    if (mul_done) begin
                        state_nxt = S_OUT;
                        load_en   = 1'b1;
                        load_val  = mul_product;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) state_nxt = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            result_o <= '0;
            zero_o   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_en) begin
                result_o <= load_val;
                zero_o   <= (load_val == '0);
            end
        end
    end

    alu_seq_mult #(
        .DATA_W    (DATA_W),
        .MUL_STEPS (MUL_STEPS)
    ) u_mult (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .start   (mul_start),
        .step    (mul_step),
        .a       (src1_i),
        .b       (src2_i),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed vector bench for alu_exec_unit
module tb_alu_exec_unit;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [3:0]  alu_ctrl_i = 4'd0;
    logic [31:0] src1_i = 32'd0;
    logic [31:0] src2_i = 32'd0;
    logic [4:0]  shamt_i = 5'd0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] result_o;
    logic        zero_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    alu_exec_unit dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .alu_ctrl_i  (alu_ctrl_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .shamt_i     (shamt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        alu_ctrl_i = op;
        src1_i     = a;
        src2_i     = b;
        shamt_i    = sh;
    endtask

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat_early);
        int n;
        int exp_lat;
`ifdef ALU_MUL_EARLY_EXIT_EN
        exp_lat = lat_early;
`else
        exp_lat = 32;
`endif
        out_ready_i = 1'b1;
        drive(OP_SMUL, a, b, 5'd0);
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        chk1({name, "_busy"}, busy_o, 1'b1);
        chk1({name, "_inrdy"}, in_ready_o, 1'b0);
        n = 0;
        while (!out_valid_o && n < 100) begin
            step();
            n++;
        end
        chk({name, "_lat"}, 32'(n), 32'(exp_lat));
        chk({name, "_res"}, result_o, exp);
        chk1({name, "_zero"}, zero_o, exp == 32'd0);
        chk1({name, "_busy_end"}, busy_o, 1'b0);
        step();
        chk1({name, "_drain"}, out_valid_o, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{OP_ADDU, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000};
        vecs[1]  = '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0};
        vecs[2]  = '{OP_OR,   32'h12340000, 32'h00005678, 5'd0,  32'h12345678};
        vecs[3]  = '{OP_LW,   32'h00001000, 32'hFFFFFFFC, 5'd0,  32'h00000FFC};
        vecs[4]  = '{OP_SW,   32'h00000010, 32'h00000020, 5'd0,  32'h00000030};
        vecs[5]  = '{OP_SUBU, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000};
        vecs[6]  = '{OP_SUBU, 32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF};
        vecs[7]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001};
        vecs[8]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000};
        vecs[9]  = '{OP_SLT,  32'h80000000, 32'h7FFFFFFF, 5'd0,  32'h00000001};
        vecs[10] = '{OP_SLTU, 32'h80000000, 32'h7FFFFFFF, 5'd0,  32'h00000000};
        vecs[11] = '{OP_SRA,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000};
        vecs[12] = '{OP_SRAV, 32'hFFFFFFE4, 32'hF0000000, 5'd0,  32'hFF000000};
        vecs[13] = '{OP_SLL,  32'h00000000, 32'h00000001, 5'd31, 32'h80000000};
        vecs[14] = '{OP_LUI,  32'h00000000, 32'hABCD1234, 5'd0,  32'h12340000};
        vecs[15] = '{OP_BLEZ, 32'h00000000, 32'h00000000, 5'd0,  32'h00000000};
        vecs[16] = '{OP_BLEZ, 32'h00000005, 32'h00000000, 5'd0,  32'h00000001};
        vecs[17] = '{OP_BLEZ, 32'h80000000, 32'h00000000, 5'd0,  32'h00000000};
        vecs[18] = '{OP_BGTZ, 32'h00000005, 32'h00000000, 5'd0,  32'h00000000};
        vecs[19] = '{OP_BGTZ, 32'h00000000, 32'h00000000, 5'd0,  32'h00000001};
        vecs[20] = '{OP_BGTZ, 32'hFFFFFFFF, 32'h00000000, 5'd0,  32'h00000001};
        vecs[21] = '{4'd15,   32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000};

        // reset state
        #12;
        chk1("rst_valid", out_valid_o, 1'b0);
        chk1("rst_inrdy", in_ready_o, 1'b1);
        chk1("rst_busy", busy_o, 1'b0);
        chk("rst_result", result_o, 32'd0);
        chk1("rst_zero", zero_o, 1'b0);
        rst_i = 1'b1;
        step();

        foreach (vecs[i]) begin
            out_ready_i = 1'b1;
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
            in_valid_i = 1'b1;
            step();
            in_valid_i = 1'b0;
            chk1($sformatf("vec%0d_valid", i), out_valid_o, 1'b1);
            chk($sformatf("vec%0d_res", i), result_o, vecs[i].exp);
            chk1($sformatf("vec%0d_zero", i), zero_o, vecs[i].exp == 32'd0);
            step();
            chk1($sformatf("vec%0d_drain", i), out_valid_o, 1'b0);
        end

        // back-to-back single-cycle ops
        out_ready_i = 1'b1;
        drive(OP_SUBU, 32'd5, 32'd5, 5'd0);
        in_valid_i = 1'b1;
        step();
        chk("b2b_first_res", result_o, 32'd0);
        chk1("b2b_first_zero", zero_o, 1'b1);
        chk1("b2b_inrdy", in_ready_o, 1'b1);
        drive(OP_SLT, 32'hFFFFFFFF, 32'd1, 5'd0);
        step();
        in_valid_i = 1'b0;
        chk1("b2b_second_valid", out_valid_o, 1'b1);
        chk("b2b_second_res", result_o, 32'd1);
        chk1("b2b_second_zero", zero_o, 1'b0);
        step();
        chk1("b2b_drain", out_valid_o, 1'b0);

        // multiplies
        run_mul("smul_m3x7", 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 3);
        run_mul("smul_min", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_mul("smul_wrap", 32'h00010000, 32'h00010000, 32'h00000000, 17);
        run_mul("smul_big", 32'd12345, -32'sd6789, 32'hFB012863, 13);
        run_mul("smul_zero", 32'd5, 32'd0, 32'h00000000, 1);

        // held result under backpressure
        out_ready_i = 1'b0;
        drive(OP_ADDU, 32'd3, 32'd4, 5'd0);
        in_valid_i = 1'b1;
        step();
        drive(OP_ADDU, 32'd100, 32'd200, 5'd0);
        for (int k = 0; k < 5; k++) begin
            chk1($sformatf("hold%0d_valid", k), out_valid_o, 1'b1);
            chk($sformatf("hold%0d_res", k), result_o, 32'd7);
            chk1($sformatf("hold%0d_inrdy", k), in_ready_o, 1'b0);
            step();
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        #1;
        chk1("hold_release_inrdy", in_ready_o, 1'b1);
        step();
        chk1("hold_drain", out_valid_o, 1'b0);
        chk("hold_res_kept", result_o, 32'd7);

        // flush in the middle of a multiply
        drive(OP_SMUL, 32'hFFFFFFFD, 32'd7, 5'd0);
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        for (int k = 0; k < 9; k++) step();
`ifndef ALU_MUL_EARLY_EXIT_EN
        chk1("flush_pre_busy", busy_o, 1'b1);
`endif
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk1("flush_busy", busy_o, 1'b0);
        chk1("flush_valid", out_valid_o, 1'b0);
        chk1("flush_inrdy", in_ready_o, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk1($sformatf("flush_quiet%0d", k), out_valid_o, 1'b0);
        end

        // flush blocks a simultaneous accept
        drive(OP_ADDU, 32'd1, 32'd1, 5'd0);
        in_valid_i = 1'b1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk1("flush_noaccept", out_valid_o, 1'b0);

        // asynchronous reset mid-multiply
        run_mul("smul_pre", 32'd6, 32'd7, 32'd42, 3);
        drive(OP_SMUL, 32'd9, 32'hFFFFFFFF, 5'd0);
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        #1;
        chk1("arst_busy", busy_o, 1'b0);
        chk1("arst_valid", out_valid_o, 1'b0);
        chk1("arst_inrdy", in_ready_o, 1'b1);
        chk("arst_result", result_o, 32'd0);
        chk1("arst_zero", zero_o, 1'b0);
        step();
        rst_i = 1'b1;
        step();
        chk1("arst_idle", out_valid_o, 1'b0);

        drive(OP_ADDU, 32'd10, 32'd20, 5'd0);
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        chk("post_rst_res", result_o, 32'd30);
        chk1("post_rst_valid", out_valid_o, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
